aes_gcm_issue_sequencer: RTL

Front-end controller for the AES-GCM encryption pipeline. It accepts one GCM instance (IV, AAD and plaintext byte lengths), then issues one phase-tagged beat per cycle into the pipeline head in this order: INIT, AAD blocks, PT blocks, LEN. It generates J0 and the 32-bit incrementing counter block, builds the length block carried as instance_size, and back-pressures the upstream block stream. The pipeline itself has no stall, so the sequencer inserts NOP bubbles when data is absent.

---
 rtl/aes_gcm_issue_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/aes_gcm_issue_sequencer.sv
// AES-GCM front-end issue sequencer: emits INIT, AAD, PT and LEN beats
// into a stall-free pipeline, inserting NOP bubbles when upstream is idle.
module aes_gcm_issue_sequencer #(
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    output logic             o_start_ready,
    input  logic [95:0]      i_iv,
    input  logic [LEN_W-1:0] i_aad_len,
    input  logic [LEN_W-1:0] i_pt_len,
    input  logic             i_blk_valid,
    input  logic [127:0]     i_blk_data,
    output logic             o_blk_ready,
    output logic [2:0]       o_phase,
    output logic [127:0]     o_h,
    output logic [127:0]     o_encrypted_j0,
    output logic [127:0]     o_encrypted_cb,
    output logic [127:0]     o_aad,
    output logic [127:0]     o_plain_text,
    output logic [127:0]     o_instance_size,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CW = LEN_W - 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AAD  = 2'd1;
    localparam logic [1:0] S_PT   = 2'd2;
    localparam logic [1:0] S_LEN  = 2'd3;

    localparam logic [2:0] PH_NOP  = 3'd0;
    localparam logic [2:0] PH_INIT = 3'd1;
    localparam logic [2:0] PH_AAD  = 3'd2;
    localparam logic [2:0] PH_PT   = 3'd3;
    localparam logic [2:0] PH_LEN  = 3'd4;

    logic [1:0]    state;
    logic [CW-1:0] aad_left;
    logic [CW-1:0] pt_left;
    logic [127:0]  cb;
    logic [LEN_W:0] aad_ext;
    logic [LEN_W:0] pt_ext;
    logic [CW-1:0] n_aad;
    logic [CW-1:0] n_pt;
    logic          accept;

    // Round byte lengths up to whole 16-byte blocks without overflow.
    assign aad_ext = {1'b0, i_aad_len} + (LEN_W + 1)'(15);
    assign pt_ext  = {1'b0, i_pt_len} + (LEN_W + 1)'(15);
    assign n_aad   = aad_ext[LEN_W:4];
    assign n_pt    = pt_ext[LEN_W:4];

    assign o_start_ready = (state == S_IDLE);
    assign o_blk_ready   = (state == S_AAD) || (state == S_PT);
    assign accept        = i_blk_valid && o_blk_ready;
    assign o_h           = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            aad_left        <= '0;
            pt_left         <= '0;
            cb              <= '0;
            o_phase         <= PH_NOP;
            o_encrypted_j0  <= '0;
            o_encrypted_cb  <= '0;
            o_aad           <= '0;
            o_plain_text    <= '0;
            o_instance_size <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
        end else begin
            o_phase      <= PH_NOP;
            o_aad        <= '0;
            o_plain_text <= '0;
            o_done       <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    o_busy <= 1'b0;
                    // The INIT beat is issued directly on start acceptance.
                    if (i_start) begin
                        o_busy          <= 1'b1;
                        o_phase         <= PH_INIT;
                        o_encrypted_j0  <= {i_iv, 32'h0000_0001};
                        o_encrypted_cb  <= {i_iv, 32'h0000_0002};
                        cb              <= {i_iv, 32'h0000_0002};
                        o_instance_size <= {64'(i_aad_len) << 3,
                                            64'(i_pt_len) << 3};
                        aad_left        <= n_aad;
                        pt_left         <= n_pt;
                        if (n_aad != '0)
                            state <= S_AAD;
                        else if (n_pt != '0)
                            state <= S_PT;
                        else
                            state <= S_LEN;
                    end
                end
                S_AAD: begin
                    if (accept) begin
                        o_phase  <= PH_AAD;
                        o_aad    <= i_blk_data;
                        aad_left <= aad_left - 1'b1;
                        if (aad_left == CW'(1))
                            state <= (pt_left != '0) ? S_PT : S_LEN;
                    end
                end
                S_PT: begin
                    if (accept) begin
                        o_phase        <= PH_PT;
                        o_plain_text   <= i_blk_data;
                        o_encrypted_cb <= cb;
                        cb             <= {cb[127:32], cb[31:0] + 32'd1};
                        pt_left        <= pt_left - 1'b1;
                        if (pt_left == CW'(1))
                            state <= S_LEN;
                    end
                end
                S_LEN: begin
                    o_phase <= PH_LEN;
                    o_done  <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
